dest_pattern_gen: RTL and testbench

//  Parametrised destination/stimulus generator that drives the VGA controller's destination and
//  sim_state inputs in place of the fixed divider + free-running counter pair. Adds a runtime

---
 rtl/dest_pattern_gen.sv | 156 +++++++++++++++
 tb/tb_dest_pattern_gen.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_pattern_gen.sv
// Destination/stimulus generator feeding vgaController: prescaled count-up, ping-pong,
// manual-step and Galois-LFSR sequencing with hold/enable control and status pulses.
//
// sim_state | meaning
// ----------+-------------------------------------------
// 00        | stopped (en low)
// 01        | ascending (count-up, manual, ping-pong up)
// 10        | descending (ping-pong down)
// 11        | random (LFSR)
module dest_pattern_gen #(
    parameter int               WIDTH    = 8,
    parameter int               DIV_W    = 24,
    parameter int               MAX_DEST = 9,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
    parameter logic [WIDTH-1:0] SEED     = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             hold,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             step_in,
    output logic [WIDTH-1:0] destination,
    output logic [1:0]       sim_state,
    output logic             adv_pulse,
    output logic             wrap_pulse
);

    localparam logic [1:0] MODE_COUNT  = 2'b00;
    localparam logic [1:0] MODE_PING   = 2'b01;
    localparam logic [1:0] MODE_MANUAL = 2'b10;
    localparam logic [1:0] MODE_LFSR   = 2'b11;

    localparam logic [1:0] ST_STOP = 2'b00;
    localparam logic [1:0] ST_UP   = 2'b01;
    localparam logic [1:0] ST_DOWN = 2'b10;
    localparam logic [1:0] ST_RAND = 2'b11;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_DEST);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;

    logic [DIV_W-1:0] presc;
    logic [WIDTH-1:0] lfsr;
    logic             dir_down;
    logic             step_q;

    logic             presc_hit;
    logic             adv;
    logic [WIDTH-1:0] lfsr_next;

    logic [WIDTH-1:0] cnt_dest;
    logic             cnt_wrap;
    logic             cnt_force;

    logic [WIDTH-1:0] pp_dest;
    logic             pp_up;
    logic             pp_wrap;
    logic             pp_force;
    logic             pp_dir_down;

    // A ">=" compare means lowering div mid-count fires on the next cycle instead of being missed.
    assign presc_hit = (div <= DIV_W'(1)) || (presc >= div - DIV_W'(1));
    assign adv       = (mode == MODE_MANUAL) ? (step_in & ~step_q) : presc_hit;
    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);

    always_comb begin
        cnt_dest  = destination + ONE;
        cnt_wrap  = 1'b0;
        cnt_force = 1'b0;
        if (destination > MAX_V) begin
            cnt_dest  = '0;
            cnt_force = 1'b1;
        end else if (destination == MAX_V) begin
            cnt_dest = '0;
            cnt_wrap = 1'b1;
        end
    end

    // Direction flips on the step that reaches an end, so sim_state shows the step just taken.
    always_comb begin
        pp_dest     = '0;
        pp_up       = 1'b1;
        pp_wrap     = 1'b0;
        pp_force    = 1'b0;
        pp_dir_down = 1'b0;
        if (destination > MAX_V) begin
            pp_force = 1'b1;
        end else if (MAX_V == '0) begin
            pp_wrap = 1'b1;
        end else begin
            pp_up       = dir_down ? (destination == '0) : (destination != MAX_V);
            pp_dest     = pp_up ? destination + ONE : destination - ONE;
            pp_wrap     = (pp_dest == MAX_V) || (pp_dest == '0);
            pp_dir_down = (pp_dest == MAX_V) ? 1'b1 : ((pp_dest == '0) ? 1'b0 : ~pp_up);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            destination <= '0;
            lfsr        <= SEED_EFF;
            dir_down    <= 1'b0;
            presc       <= '0;
            step_q      <= 1'b0;
            sim_state   <= ST_STOP;
            adv_pulse   <= 1'b0;
            wrap_pulse  <= 1'b0;
        end else begin
            step_q     <= step_in;
            adv_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (!en) begin
                presc     <= '0;
                sim_state <= ST_STOP;
            end else if (!hold) begin
                if (mode == MODE_MANUAL || adv) presc <= '0;
                else                            presc <= presc + DIV_W'(1);
                case (mode)
                    MODE_COUNT, MODE_MANUAL: begin
                        sim_state <= ST_UP;
                        if (adv) begin
                            destination <= cnt_dest;
                            wrap_pulse  <= cnt_wrap;
                            adv_pulse   <= 1'b1;
                            if (cnt_force) dir_down <= 1'b0;
                        end
                    end
                    MODE_PING: begin
                        if (adv) begin
                            destination <= pp_dest;
                            dir_down    <= pp_dir_down;
                            wrap_pulse  <= pp_wrap;
                            adv_pulse   <= 1'b1;
                            sim_state   <= (pp_up || pp_force) ? ST_UP : ST_DOWN;
                        end else if (sim_state == ST_STOP || sim_state == ST_RAND) begin
                            sim_state <= dir_down ? ST_DOWN : ST_UP;
                        end
                    end
                    default: begin
                        sim_state <= ST_RAND;
                        if (adv) begin
                            lfsr        <= lfsr_next;
                            destination <= lfsr_next;
                            wrap_pulse  <= (lfsr_next == SEED_EFF);
                            adv_pulse   <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dest_pattern_gen.sv
// Bench for dest_pattern_gen: four instances (MAX_DEST 5/3/9/0) share one stimulus stream and are
// compared every cycle against a sequence-level model, plus literal checks of the key scenarios.
module tb_dest_pattern_gen;

    logic        clk = 1'b0;
    logic        rst, en, hold, step_in;
    logic [1:0]  mode;
    logic [23:0] div;

    logic [7:0]  dest_o [4];
    logic [1:0]  sim_o  [4];
    logic        adv_o  [4];
    logic        wrap_o [4];

    always #5 clk = ~clk;

    dest_pattern_gen #(.MAX_DEST(5)) u_a (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .mode(mode), .div(div), .step_in(step_in),
        .destination(dest_o[0]), .sim_state(sim_o[0]), .adv_pulse(adv_o[0]), .wrap_pulse(wrap_o[0]));
    dest_pattern_gen #(.MAX_DEST(3)) u_b (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .mode(mode), .div(div), .step_in(step_in),
        .destination(dest_o[1]), .sim_state(sim_o[1]), .adv_pulse(adv_o[1]), .wrap_pulse(wrap_o[1]));
    dest_pattern_gen #(.MAX_DEST(9)) u_c (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .mode(mode), .div(div), .step_in(step_in),
        .destination(dest_o[2]), .sim_state(sim_o[2]), .adv_pulse(adv_o[2]), .wrap_pulse(wrap_o[2]));
    dest_pattern_gen #(.MAX_DEST(0), .SEED(8'h00)) u_d (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .mode(mode), .div(div), .step_in(step_in),
        .destination(dest_o[3]), .sim_state(sim_o[3]), .adv_pulse(adv_o[3]), .wrap_pulse(wrap_o[3]));

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Model state per instance; sim_state is only pinned where its value is unambiguous.
    int mmax  [4] = '{5, 3, 9, 0};
    int mseed [4] = '{1, 1, 1, 1};
    int m_dest[4], m_up[4], m_lfsr[4], m_cnt[4], m_stepq[4];
    int m_sim[4], m_simk[4], m_adv[4], m_wrap[4];

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            bit go;
            bit rise;
            int d;
            int goup;
            go = 1'b0;
            if (rst) begin
                m_dest[i] = 0; m_lfsr[i] = mseed[i]; m_up[i] = 1; m_cnt[i] = 0; m_stepq[i] = 0;
                m_sim[i] = 0; m_simk[i] = 1; m_adv[i] = 0; m_wrap[i] = 0;
                continue;
            end
            m_adv[i]   = 0;
            m_wrap[i]  = 0;
            rise       = step_in && (m_stepq[i] == 0);
            m_stepq[i] = int'(step_in);
            if (!en) begin
                m_cnt[i] = 0; m_sim[i] = 0; m_simk[i] = 1;
            end else if (!hold) begin
                if (mode == 2'b10) begin
                    m_cnt[i] = 0;
                    go = rise;
                end else begin
                    d = (div < 2) ? 1 : int'(div);
                    if (m_cnt[i] + 1 >= d) begin go = 1'b1; m_cnt[i] = 0; end
                    else m_cnt[i]++;
                end
                if (mode == 2'b11) begin
                    m_sim[i] = 3; m_simk[i] = 1;
                    if (go) begin
                        m_lfsr[i] = (m_lfsr[i] >> 1) ^ (((m_lfsr[i] & 1) != 0) ? 'hB8 : 0);
                        m_dest[i] = m_lfsr[i];
                        m_wrap[i] = int'(m_lfsr[i] == mseed[i]);
                        m_adv[i]  = 1;
                    end
                end else if (mode == 2'b01) begin
                    m_simk[i] = 0;
                    if (go) begin
                        m_adv[i] = 1; m_simk[i] = 1;
                        if (m_dest[i] > mmax[i]) begin
                            m_dest[i] = 0; m_up[i] = 1; m_sim[i] = 1;
                        end else if (mmax[i] == 0) begin
                            m_wrap[i] = 1; m_up[i] = 1; m_sim[i] = 1;
                        end else begin
                            goup      = (m_up[i] != 0) ? int'(m_dest[i] < mmax[i]) : int'(m_dest[i] == 0);
                            m_dest[i] = (goup != 0) ? m_dest[i] + 1 : m_dest[i] - 1;
                            m_sim[i]  = (goup != 0) ? 1 : 2;
                            m_wrap[i] = int'(m_dest[i] == mmax[i] || m_dest[i] == 0);
                            if (m_dest[i] == mmax[i]) m_up[i] = 0;
                            else if (m_dest[i] == 0)  m_up[i] = 1;
                            else                      m_up[i] = goup;
                        end
                    end
                end else begin
                    m_sim[i] = 1; m_simk[i] = 1;
                    if (go) begin
                        m_adv[i] = 1;
                        if (m_dest[i] > mmax[i]) begin m_dest[i] = 0; m_up[i] = 1; end
                        else if (m_dest[i] == mmax[i]) begin m_dest[i] = 0; m_wrap[i] = 1; end
                        else m_dest[i]++;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("model_dest[%0d]", i), int'(dest_o[i]), m_dest[i]);
                chk($sformatf("model_adv[%0d]", i),  int'(adv_o[i]),  m_adv[i]);
                chk($sformatf("model_wrap[%0d]", i), int'(wrap_o[i]), m_wrap[i]);
                if (m_simk[i] != 0) chk($sformatf("model_sim[%0d]", i), int'(sim_o[i]), m_sim[i]);
            end
        end
    end

    int exp_pp[7] = '{1, 2, 3, 2, 1, 0, 1};
    int exp_ps[7] = '{1, 1, 1, 2, 2, 2, 1};
    int exp_lf[5] = '{'hB8, 'h5C, 'h2E, 'h17, 'hB3};

    initial begin
        int nw;
        int na;
        rst = 1'b1; en = 1'b1; hold = 1'b1; mode = 2'b11; div = 24'hABCDEF; step_in = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_dest", int'(dest_o[i]), 0);
            chk("rst_sim",  int'(sim_o[i]),  0);
            chk("rst_adv",  int'(adv_o[i]),  0);
            chk("rst_wrap", int'(wrap_o[i]), 0);
        end
        chk_en = 1'b1;

        // count-up, div=3, MAX_DEST=5
        rst = 1'b0; hold = 1'b0; mode = 2'b00; div = 24'd3; step_in = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            chk("cnt_adv",  int'(adv_o[0]),  int'(c % 3 == 0));
            chk("cnt_dest", int'(dest_o[0]), (c / 3) % 6);
            chk("cnt_wrap", int'(wrap_o[0]), int'(c == 18));
        end

        rst = 1'b1;
        @(negedge clk);
        chk("midrst_dest_b", int'(dest_o[1]), 0);
        chk("midrst_dest_c", int'(dest_o[2]), 0);
        chk("midrst_sim_c",  int'(sim_o[2]),  0);

        // ping-pong, div=1, MAX_DEST=3
        rst = 1'b0; mode = 2'b01; div = 24'd1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("pp_dest", int'(dest_o[1]), exp_pp[k]);
            chk("pp_sim",  int'(sim_o[1]),  exp_ps[k]);
            chk("pp_wrap", int'(wrap_o[1]), int'(k == 2 || k == 5));
        end

        // LFSR from reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mode = 2'b11; div = 24'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lfsr_dest", int'(dest_o[2]), exp_lf[k]);
            chk("lfsr_sim",  int'(sim_o[2]),  3);
            chk("lfsr_wrap", int'(wrap_o[2]), 0);
        end
        nw = 0;
        for (int k = 6; k <= 255; k++) begin
            @(negedge clk);
            if (wrap_o[2]) nw++;
        end
        chk("lfsr_period_wraps", nw, 1);
        chk("lfsr_period_end_dest", int'(dest_o[2]), 1);
        chk("lfsr_period_end_wrap", int'(wrap_o[2]), 1);

        // out-of-range leftover into count-up
        @(negedge clk);
        chk("lfsr_b8", int'(dest_o[2]), 'hB8);
        mode = 2'b00; div = 24'd2;
        @(negedge clk);
        chk("switch_noadv", int'(adv_o[2]), 0);
        chk("switch_hold_dest", int'(dest_o[2]), 'hB8);
        @(negedge clk);
        chk("force_dest", int'(dest_o[2]), 0);
        chk("force_adv",  int'(adv_o[2]),  1);
        chk("force_wrap", int'(wrap_o[2]), 0);

        // hold mid-count keeps prescaler phase
        div = 24'd4;
        repeat (2) @(negedge clk);
        hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_dest", int'(dest_o[2]), 0);
            chk("hold_adv",  int'(adv_o[2]),  0);
            chk("hold_sim",  int'(sim_o[2]),  1);
        end
        hold = 1'b0;
        @(negedge clk);
        chk("release_adv1", int'(adv_o[2]), 0);
        @(negedge clk);
        chk("release_adv2", int'(adv_o[2]), 1);
        chk("release_dest", int'(dest_o[2]), 1);

        // en=0 stops and clears the prescaler
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en0_sim", int'(sim_o[2]), 0);
        en = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("en1_adv", int'(adv_o[2]), int'(c == 4));
        end
        chk("en1_dest", int'(dest_o[2]), 2);

        // lowering div mid-count
        div = 24'd8;
        repeat (3) @(negedge clk);
        div = 24'd2;
        @(negedge clk);
        chk("lowdiv_adv",  int'(adv_o[2]),  1);
        chk("lowdiv_dest", int'(dest_o[2]), 3);

        // manual stepping
        mode = 2'b10; div = 24'd5; step_in = 1'b0;
        @(negedge clk);
        na = 0;
        for (int k = 0; k < 7; k++) begin
            step_in = (k < 5);
            @(negedge clk);
            if (adv_o[2]) na++;
        end
        chk("man_one_adv", na, 1);
        chk("man_dest", int'(dest_o[2]), 4);
        na = 0;
        for (int k = 0; k < 9; k++) begin
            hold    = (k < 2);
            en      = !(k >= 5 && k < 7);
            step_in = (k < 4) || (k >= 5 && k < 9);
            @(negedge clk);
            if (adv_o[2]) na++;
        end
        chk("man_no_false_edge", na, 0);
        chk("man_dest_kept", int'(dest_o[2]), 4);
        step_in = 1'b0;
        @(negedge clk);
        step_in = 1'b1;
        @(negedge clk);
        chk("man_step_adv", int'(adv_o[2]), 1);
        chk("man_step_dest", int'(dest_o[2]), 5);
        step_in = 1'b0;

        // ping-pong from out-of-range leftover
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mode = 2'b11; div = 24'd0;
        @(negedge clk);
        mode = 2'b01; div = 24'd1;
        @(negedge clk);
        chk("pp_force_dest", int'(dest_o[2]), 0);
        chk("pp_force_wrap", int'(wrap_o[2]), 0);
        chk("pp_force_sim",  int'(sim_o[2]),  1);
        repeat (12) @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
